// File: rtl/adp_seg_pkg.sv
// Shared types and widths for the adaptive-threshold segmentation frame controller.
// Provides the input FSM states, config bundle and a saturating counter helper.
package adp_seg_pkg;

    localparam int GAIN_W = 5;
    localparam int CNT_W  = 12;
    localparam int FCNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LINE,
        S_HBLK
    } state_t;

    typedef struct packed {
        logic [GAIN_W-1:0] gain;
        logic              bypass;
    } cfg_t;

    // Geometry counters stick at all-ones instead of wrapping, so an
    // oversized line or frame can never alias back to a legal length.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adp_seg_frame_ctrl_if.sv
// Run-time configuration handshake for the segmentation frame controller.
// master: cfg_valid/cfg_gain/cfg_bypass out, cfg_ready in; slave: the reverse.
interface adp_seg_frame_ctrl_if;
    import adp_seg_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [GAIN_W-1:0] cfg_gain;
    logic              cfg_bypass;

    modport master (
        output cfg_valid,
        output cfg_gain,
        output cfg_bypass,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_gain,
        input  cfg_bypass,
        output cfg_ready
    );

endinterface

// File: rtl/adp_seg_border_mask.sv
// Output-side border blanking: tracks x/y of the datapath stream and zeroes the
// invalid 1-pixel border of the 3x3 result. Ports: seg_* stream in, bypass in,
// out_* (all delayed one cycle) out.
module adp_seg_border_mask
    import adp_seg_pkg::*;
#(
    parameter logic [CNT_W-1:0] H_DISP = 12'd640,
    parameter logic [CNT_W-1:0] V_DISP = 12'd480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_vsync,
    input  logic       seg_hsync,
    input  logic       seg_de,
    input  logic [7:0] seg_data,
    input  logic       bypass,
    output logic       out_vsync,
    output logic       out_hsync,
    output logic       out_de,
    output logic [7:0] out_data
);

    logic [CNT_W-1:0] x_out;
    logic [CNT_W-1:0] y_out;
    logic             vs_rise;
    logic             de_fall;
    logic             border;
    logic [7:0]       pix;

    // The delayed out_vsync/out_de double as the previous-cycle samples.
    assign vs_rise = seg_vsync & ~out_vsync;
    assign de_fall = ~seg_de & out_de;

    assign border = (x_out == '0)
                  | (x_out == H_DISP - 12'd1)
                  | (y_out == '0)
                  | (y_out == V_DISP - 12'd1);

    assign pix = (seg_de & (~border | bypass)) ? seg_data : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= 8'h00;
            x_out     <= '0;
            y_out     <= '0;
        end else begin
            out_vsync <= seg_vsync;
            out_hsync <= seg_hsync;
            out_de    <= seg_de;
            out_data  <= pix;
            if (vs_rise) begin
                x_out <= '0;
                y_out <= '0;
            end else if (seg_de) begin
                x_out <= sat_inc(x_out);
            end else if (de_fall) begin
                x_out <= '0;
                y_out <= sat_inc(y_out);
            end
        end
    end

endmodule

// File: rtl/adp_seg_frame_ctrl.sv
// Frame-level controller: input geometry FSM, config shadowing at frame start,
// frame counting, sticky geometry errors and the output border mask.
// Ports: clk/rst, Y_* input sync, seg_* datapath stream, cfg handshake (slave),
// err_clr; gain_act, out_*, frame_cnt, frame_done, err_hlen, err_vlen.
module adp_seg_frame_ctrl
    import adp_seg_pkg::*;
#(
    parameter logic [CNT_W-1:0]  H_DISP   = 12'd640,
    parameter logic [CNT_W-1:0]  V_DISP   = 12'd480,
    parameter logic [GAIN_W-1:0] GAIN_RST = 5'd25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Y_vsync,
    input  logic              Y_hsync,
    input  logic              Y_de,
    input  logic              seg_vsync,
    input  logic              seg_hsync,
    input  logic              seg_de,
    input  logic [7:0]        seg_data,
    adp_seg_frame_ctrl_if.slave cfg,
    input  logic              err_clr,
    output logic [GAIN_W-1:0] gain_act,
    output logic              out_vsync,
    output logic              out_hsync,
    output logic              out_de,
    output logic [7:0]        out_data,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              frame_done,
    output logic              err_hlen,
    output logic              err_vlen
);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] x_in;
    logic [CNT_W-1:0] x_n;
    logic [CNT_W-1:0] y_in;
    logic [CNT_W-1:0] y_n;
    logic             vs_q;
    logic             de_q;
    logic             hs_q;
    logic             vs_rise;
    logic             de_rise;
    logic             line_end;
    logic             close;
    logic             hlen_set;
    logic             vlen_set;

    cfg_t             pend;
    logic             pend_valid;
    cfg_t             act;
    logic             ready;
    logic             accept;

    assign vs_rise  = Y_vsync & ~vs_q;
    assign de_rise  = Y_de & ~de_q;
    // A line also ends if hsync arrives while de is still high.
    assign line_end = (~Y_de & de_q) | (Y_hsync & ~hs_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            x_in  <= '0;
            y_in  <= '0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
        end else begin
            state <= state_n;
            x_in  <= x_n;
            y_in  <= y_n;
            vs_q  <= Y_vsync;
            de_q  <= Y_de;
            hs_q  <= Y_hsync;
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x_in;
        y_n      = y_in;
        close    = 1'b0;
        hlen_set = 1'b0;
        vlen_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (vs_rise) begin
                    state_n = S_WAIT;
                    y_n     = '0;
                end
            end
            S_WAIT, S_HBLK: begin
                if (vs_rise) begin
                    state_n  = S_WAIT;
                    close    = 1'b1;
                    vlen_set = (y_in != V_DISP);
                    y_n      = '0;
                end else if (de_rise) begin
                    state_n = S_LINE;
                    x_n     = 12'd1;
                    y_n     = sat_inc(y_in);
                end
            end
            S_LINE: begin
                if (line_end) begin
                    state_n  = S_HBLK;
                    hlen_set = (x_in != H_DISP);
                end else if (Y_de) begin
                    x_n = sat_inc(x_in);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            err_hlen   <= 1'b0;
            err_vlen   <= 1'b0;
        end else begin
            frame_done <= close;
            if (close) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            err_hlen <= hlen_set | (err_hlen & ~err_clr);
            err_vlen <= vlen_set | (err_vlen & ~err_clr);
        end
    end

    assign accept        = cfg.cfg_valid & ready;
    assign cfg.cfg_ready = ready;
    assign gain_act      = act.gain;

    // ready stays low through the apply cycle and returns one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            pend_valid <= 1'b0;
            act        <= '{gain: GAIN_RST, bypass: 1'b0};
            ready      <= 1'b1;
        end else begin
            ready <= ~pend_valid & ~accept;
            if (vs_rise) begin
                if (accept) begin
                    act <= '{gain: cfg.cfg_gain, bypass: cfg.cfg_bypass};
                end else if (pend_valid) begin
                    act        <= pend;
                    pend_valid <= 1'b0;
                end
            end else if (accept) begin
                pend       <= '{gain: cfg.cfg_gain, bypass: cfg.cfg_bypass};
                pend_valid <= 1'b1;
            end
        end
    end

    adp_seg_border_mask #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP)
    ) u_mask (
        .clk       (clk),
        .rst       (rst),
        .seg_vsync (seg_vsync),
        .seg_hsync (seg_hsync),
        .seg_de    (seg_de),
        .seg_data  (seg_data),
        .bypass    (act.bypass),
        .out_vsync (out_vsync),
        .out_hsync (out_hsync),
        .out_de    (out_de),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_adp_seg_frame_ctrl.sv
// Directed bench for adp_seg_frame_ctrl with an 8x6 frame geometry.
// Covers geometry errors, config shadowing, border masking and mid-line reset.
module tb_adp_seg_frame_ctrl;

    localparam int H = 8;
    localparam int V = 6;

    logic        clk;
    logic        rst;
    logic        Y_vsync;
    logic        Y_hsync;
    logic        Y_de;
    logic        seg_vsync;
    logic        seg_hsync;
    logic        seg_de;
    logic [7:0]  seg_data;
    logic        err_clr;
    logic [4:0]  gain_act;
    logic        out_vsync;
    logic        out_hsync;
    logic        out_de;
    logic [7:0]  out_data;
    logic [15:0] frame_cnt;
    logic        frame_done;
    logic        err_hlen;
    logic        err_vlen;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    bit exp_byp  = 0;

    adp_seg_frame_ctrl_if cfg_if ();

    adp_seg_frame_ctrl #(
        .H_DISP   (12'd8),
        .V_DISP   (12'd6),
        .GAIN_RST (5'd25)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Y_vsync    (Y_vsync),
        .Y_hsync    (Y_hsync),
        .Y_de       (Y_de),
        .seg_vsync  (seg_vsync),
        .seg_hsync  (seg_hsync),
        .seg_de     (seg_de),
        .seg_data   (seg_data),
        .cfg        (cfg_if.slave),
        .err_clr    (err_clr),
        .gain_act   (gain_act),
        .out_vsync  (out_vsync),
        .out_hsync  (out_hsync),
        .out_de     (out_de),
        .out_data   (out_data),
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done),
        .err_hlen   (err_hlen),
        .err_vlen   (err_vlen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix_exp(input int r, input int c);
        if (exp_byp) return 8'hFF;
        if (r == 0 || r == V - 1 || c == 0 || c == H - 1) return 8'h00;
        return 8'hFF;
    endfunction

    task automatic line(input int len, input int row, input bit chk);
        for (int i = 0; i < len; i++) begin
            Y_de   = 1'b1;
            seg_de = 1'b1;
            tick();
            if (chk) begin
                check_eq($sformatf("pix r%0d c%0d", row, i), out_data,
                         pix_exp(row, i));
                check_eq("out_de hi", out_de, 1);
            end
        end
        Y_de      = 1'b0;
        seg_de    = 1'b0;
        Y_hsync   = 1'b1;
        seg_hsync = 1'b1;
        tick();
        if (chk) begin
            check_eq("out_de lo", out_de, 0);
            check_eq("out_data blank", out_data, 0);
        end
        Y_hsync   = 1'b0;
        seg_hsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic vs_pulse();
        Y_vsync   = 1'b1;
        seg_vsync = 1'b1;
        tick();
        check_eq("out_vsync", out_vsync, 1);
        Y_vsync   = 1'b0;
        seg_vsync = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst              = 1'b1;
        Y_vsync          = 1'b0;
        Y_hsync          = 1'b0;
        Y_de             = 1'b0;
        seg_vsync        = 1'b0;
        seg_hsync        = 1'b0;
        seg_de           = 1'b0;
        seg_data         = 8'hFF;
        err_clr          = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_gain   = 5'd0;
        cfg_if.cfg_bypass = 1'b0;
        tick();
        tick();
        check_eq("rst frame_cnt", frame_cnt, 0);
        check_eq("rst frame_done", frame_done, 0);
        check_eq("rst err_hlen", err_hlen, 0);
        check_eq("rst err_vlen", err_vlen, 0);
        check_eq("rst gain_act", gain_act, 25);
        check_eq("rst cfg_ready", cfg_if.cfg_ready, 1);
        check_eq("rst out_data", out_data, 0);
        check_eq("rst out_de", out_de, 0);
        rst = 1'b0;
        tick();

        // two clean frames, masking checked on the second
        vs_pulse();
        for (int r = 0; r < V; r++) line(H, r, 0);
        vs_pulse();
        for (int r = 0; r < V; r++) line(H, r, 1);
        vs_pulse();
        check_eq("t1 frame_cnt", frame_cnt, 2);
        check_eq("t1 done pulses", done_cnt, 2);
        check_eq("t1 err_hlen", err_hlen, 0);
        check_eq("t1 err_vlen", err_vlen, 0);

        // short line 3
        for (int r = 0; r < 3; r++) line(r == 2 ? H - 1 : H, r, 0);
        check_eq("t2 err_hlen set", err_hlen, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t2 err_hlen clr", err_hlen, 0);
        for (int r = 3; r < V; r++) line(H, r, 0);
        vs_pulse();
        check_eq("t2 frame_cnt", frame_cnt, 3);
        check_eq("t2 err_vlen", err_vlen, 0);

        // config mid-frame
        line(H, 0, 0);
        line(H, 1, 0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_gain  = 5'd9;
        tick();
        cfg_if.cfg_valid = 1'b0;
        check_eq("t3 ready lo", cfg_if.cfg_ready, 0);
        check_eq("t3 gain held", gain_act, 25);
        for (int r = 2; r < V; r++) line(H, r, 0);
        check_eq("t3 gain held late", gain_act, 25);
        Y_vsync   = 1'b1;
        seg_vsync = 1'b1;
        tick();
        check_eq("t3 gain applied", gain_act, 9);
        check_eq("t3 ready still lo", cfg_if.cfg_ready, 0);
        check_eq("t3 frame_cnt", frame_cnt, 4);
        Y_vsync   = 1'b0;
        seg_vsync = 1'b0;
        tick();
        check_eq("t3 ready back", cfg_if.cfg_ready, 1);
        tick();

        // short frame, then clear colliding with a new error
        for (int r = 0; r < 5; r++) line(H, r, 0);
        vs_pulse();
        check_eq("t5 err_vlen", err_vlen, 1);
        check_eq("t5 frame_cnt", frame_cnt, 5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t5 err_vlen clr", err_vlen, 0);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_gain   = 5'd9;
        cfg_if.cfg_bypass = 1'b1;
        tick();
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_bypass = 1'b0;
        for (int r = 0; r < 5; r++) line(H, r, 0);
        Y_vsync   = 1'b1;
        seg_vsync = 1'b1;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("t5 err wins clr", err_vlen, 1);
        check_eq("t5 frame_cnt 2", frame_cnt, 6);
        Y_vsync   = 1'b0;
        seg_vsync = 1'b0;
        tick();
        tick();

        // bypass now active: border pixels pass
        exp_byp = 1;
        line(H, 0, 1);

        // reset mid-line
        Y_de   = 1'b1;
        seg_de = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("t6 out_de", out_de, 0);
        check_eq("t6 out_data", out_data, 0);
        check_eq("t6 frame_cnt", frame_cnt, 0);
        check_eq("t6 gain_act", gain_act, 25);
        check_eq("t6 err_vlen", err_vlen, 0);
        check_eq("t6 cfg_ready", cfg_if.cfg_ready, 1);
        Y_de   = 1'b0;
        seg_de = 1'b0;
        tick();
        rst = 1'b0;
        exp_byp = 0;
        tick();
        vs_pulse();
        check_eq("t6 idle no count", frame_cnt, 0);
        for (int r = 0; r < V; r++) line(H, r, 1);
        vs_pulse();
        check_eq("t6 frame_cnt", frame_cnt, 1);
        check_eq("t6 err_hlen", err_hlen, 0);
        check_eq("t6 err_vlen end", err_vlen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
